// File: rtl/decode.sv
// RV32I decode stage: register file with write-back bypass, immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module decode #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     i_fetch_pc,
  input  logic [31:0]     i_fetch_pc_inc,
  input  logic [31:0]     i_fetch_inst,
  input  logic            i_flush,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_stall,
  output logic            o_dec_valid,
  output logic [31:0]     o_dec_pc,
  output logic [31:0]     o_dec_pc_inc,
  output logic [XLEN-1:0] o_dec_rs1_data,
  output logic [XLEN-1:0] o_dec_rs2_data,
  output logic [31:0]     o_dec_imm,
  output logic [4:0]      o_dec_rd,
  output logic [6:0]      o_dec_opcode,
  output logic [2:0]      o_dec_funct3,
  output logic            o_dec_funct7b5
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic            valid;
    logic [31:0]     pc;
    logic [31:0]     pc_inc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [31:0]     imm;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
  } idex_t;

  logic [XLEN-1:0] r_regs [NUM_REGS];
  idex_t           r_idex;
  idex_t           w_idex_nxt;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;
  logic [31:0]     w_imm;
  logic            w_uses_rs1, w_uses_rs2, w_hazard;
  logic            w_wb_live;

  assign w_opcode  = i_fetch_inst[6:0];
  assign w_rd      = i_fetch_inst[11:7];
  assign w_rs1     = i_fetch_inst[19:15];
  assign w_rs2     = i_fetch_inst[24:20];
  assign w_wb_live = i_wb_en && (i_wb_rd != 5'd0);

  // Bypass lets an instruction see a value retiring in the same cycle it is decoded.
  always_comb begin
    w_rs1_data = r_regs[w_rs1];
    w_rs2_data = r_regs[w_rs2];
    if (w_wb_live && i_wb_rd == w_rs1) w_rs1_data = i_wb_data;
    if (w_wb_live && i_wb_rd == w_rs2) w_rs2_data = i_wb_data;
    if (w_rs1 == 5'd0) w_rs1_data = '0;
    if (w_rs2 == 5'd0) w_rs2_data = '0;
  end

  always_comb begin
    w_imm = '0;
    case (w_opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        w_imm = {{20{i_fetch_inst[31]}}, i_fetch_inst[31:20]};
      OP_STORE:
        w_imm = {{20{i_fetch_inst[31]}}, i_fetch_inst[31:25], i_fetch_inst[11:7]};
      OP_BRANCH:
        w_imm = {{19{i_fetch_inst[31]}}, i_fetch_inst[31], i_fetch_inst[7],
                 i_fetch_inst[30:25], i_fetch_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm = {i_fetch_inst[31:12], 12'b0};
      OP_JAL:
        w_imm = {{11{i_fetch_inst[31]}}, i_fetch_inst[31], i_fetch_inst[19:12],
                 i_fetch_inst[20], i_fetch_inst[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  assign w_uses_rs1 = (w_opcode != OP_LUI) && (w_opcode != OP_AUIPC) && (w_opcode != OP_JAL);
  assign w_uses_rs2 = (w_opcode == OP_REG) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);

  // Load result is not available until after EX/MEM, so a dependent consumer waits one slot.
  assign w_hazard = r_idex.valid && (r_idex.opcode == OP_LOAD) && (r_idex.rd != 5'd0) &&
                    ((w_uses_rs1 && w_rs1 == r_idex.rd) || (w_uses_rs2 && w_rs2 == r_idex.rd));
  assign o_stall  = w_hazard && !i_flush;

  always_comb begin
    w_idex_nxt.valid    = (i_fetch_inst != 32'h0) && !i_flush && !w_hazard;
    w_idex_nxt.pc       = i_fetch_pc;
    w_idex_nxt.pc_inc   = i_fetch_pc_inc;
    w_idex_nxt.rs1_data = w_rs1_data;
    w_idex_nxt.rs2_data = w_rs2_data;
    w_idex_nxt.imm      = w_imm;
    w_idex_nxt.rd       = w_rd;
    w_idex_nxt.opcode   = w_opcode;
    w_idex_nxt.funct3   = i_fetch_inst[14:12];
    w_idex_nxt.funct7b5 = i_fetch_inst[30];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idex <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_idex <= w_idex_nxt;
      if (w_wb_live) r_regs[i_wb_rd] <= i_wb_data;
    end
  end

  assign o_dec_valid    = r_idex.valid;
  assign o_dec_pc       = r_idex.pc;
  assign o_dec_pc_inc   = r_idex.pc_inc;
  assign o_dec_rs1_data = r_idex.rs1_data;
  assign o_dec_rs2_data = r_idex.rs2_data;
  assign o_dec_imm      = r_idex.imm;
  assign o_dec_rd       = r_idex.rd;
  assign o_dec_opcode   = r_idex.opcode;
  assign o_dec_funct3   = r_idex.funct3;
  assign o_dec_funct7b5 = r_idex.funct7b5;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: driver queues expected ID/EX contents, monitor checks them.
module tb_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_fetch_pc, i_fetch_pc_inc, i_fetch_inst;
  logic        i_flush, i_wb_en;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        o_stall, o_dec_valid, o_dec_funct7b5;
  logic [31:0] o_dec_pc, o_dec_pc_inc, o_dec_rs1_data, o_dec_rs2_data, o_dec_imm;
  logic [4:0]  o_dec_rd;
  logic [6:0]  o_dec_opcode;
  logic [2:0]  o_dec_funct3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        full;
    logic        valid;
    logic [31:0] pc, pc_inc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } exp_t;

  exp_t q[$];

  decode dut (
    .clk(clk), .reset(reset),
    .i_fetch_pc(i_fetch_pc), .i_fetch_pc_inc(i_fetch_pc_inc), .i_fetch_inst(i_fetch_inst),
    .i_flush(i_flush), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_stall(o_stall), .o_dec_valid(o_dec_valid), .o_dec_pc(o_dec_pc),
    .o_dec_pc_inc(o_dec_pc_inc), .o_dec_rs1_data(o_dec_rs1_data),
    .o_dec_rs2_data(o_dec_rs2_data), .o_dec_imm(o_dec_imm), .o_dec_rd(o_dec_rd),
    .o_dec_opcode(o_dec_opcode), .o_dec_funct3(o_dec_funct3), .o_dec_funct7b5(o_dec_funct7b5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares the ID/EX register one edge after each issued vector.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("valid", {31'd0, o_dec_valid}, {31'd0, e.valid});
      if (e.full) begin
        chk("pc",       o_dec_pc,       e.pc);
        chk("pc_inc",   o_dec_pc_inc,   e.pc_inc);
        chk("rs1_data", o_dec_rs1_data, e.rs1);
        chk("rs2_data", o_dec_rs2_data, e.rs2);
        chk("imm",      o_dec_imm,      e.imm);
        chk("rd",       {27'd0, o_dec_rd},       {27'd0, e.rd});
        chk("opcode",   {25'd0, o_dec_opcode},   {25'd0, e.op});
        chk("funct3",   {29'd0, o_dec_funct3},   {29'd0, e.f3});
        chk("funct7b5", {31'd0, o_dec_funct7b5}, {31'd0, e.f7});
      end
    end
  end

  // One cycle of stimulus; stall is combinational so it is checked right here.
  task automatic step(input logic rst_n, input logic [31:0] inst, input logic [31:0] pc,
                      input logic flush, input logic wb_en, input logic [4:0] wb_rd,
                      input logic [31:0] wb_data, input logic exp_stall,
                      input logic full, input logic exp_valid, input logic [4:0] exp_rd,
                      input logic [31:0] exp_rs1, input logic [31:0] exp_rs2,
                      input logic [31:0] exp_imm);
    exp_t e;
    @(negedge clk);
    reset = rst_n; i_fetch_inst = inst; i_fetch_pc = pc; i_fetch_pc_inc = pc + 32'd4;
    i_flush = flush; i_wb_en = wb_en; i_wb_rd = wb_rd; i_wb_data = wb_data;
    #1;
    if (rst_n) chk("stall", {31'd0, o_stall}, {31'd0, exp_stall});
    e.full = full; e.valid = exp_valid; e.rd = exp_rd;
    e.rs1 = exp_rs1; e.rs2 = exp_rs2; e.imm = exp_imm;
    if (rst_n) begin
      e.pc = pc; e.pc_inc = pc + 32'd4;
      e.op = inst[6:0]; e.f3 = inst[14:12]; e.f7 = inst[30];
    end else begin
      e.pc = '0; e.pc_inc = '0; e.op = '0; e.f3 = '0; e.f7 = 1'b0;
    end
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b0; i_fetch_inst = '0; i_fetch_pc = '0; i_fetch_pc_inc = '0;
    i_flush = 1'b0; i_wb_en = 1'b0; i_wb_rd = '0; i_wb_data = '0;

    // Reset held two cycles with a live instruction present: everything stays zero.
    step(0, 32'h00500093, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 32'h00500093, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // addi x1,x0,5; also write back x1=5 this cycle.
    step(1, 32'h00500093, 32'h10, 0, 1, 5'd1, 32'd5, 0, 1, 1, 5'd1, 0, 0, 32'd5);
    // add x6,x5,x0 with same-cycle write of x5.
    step(1, 32'h00028333, 32'h14, 0, 1, 5'd5, 32'hDEADBEEF, 0, 1, 1, 5'd6, 32'hDEADBEEF, 0, 0);
    // add x7,x5,x1 later: register file holds both values.
    step(1, 32'h001283B3, 32'h18, 0, 0, 0, 0, 0, 1, 1, 5'd7, 32'hDEADBEEF, 32'd5, 0);
    // lw x2,0(x1) then dependent add x3,x2,x2: one stall cycle, bubble, then add.
    step(1, 32'h0000A103, 32'h1C, 0, 0, 0, 0, 0, 1, 1, 5'd2, 32'd5, 0, 0);
    step(1, 32'h002101B3, 32'h20, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 32'h002101B3, 32'h20, 0, 0, 0, 0, 0, 1, 1, 5'd3, 0, 0, 0);
    // Same pair with flush in the would-be stall cycle; write to x0 is dropped.
    step(1, 32'h0000A103, 32'h24, 0, 0, 0, 0, 0, 1, 1, 5'd2, 32'd5, 0, 0);
    step(1, 32'h002101B3, 32'h28, 1, 1, 5'd0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0);
    // add x8,x0,x0 with a live write to x0 in the same cycle: x0 reads 0.
    step(1, 32'h00000433, 32'h2C, 0, 1, 5'd0, 32'h1234, 0, 1, 1, 5'd8, 0, 0, 0);
    // beq x0,x0,-4 and lui x5,0x12345.
    step(1, 32'hFE000EE3, 32'h30, 0, 0, 0, 0, 0, 1, 1, 5'd29, 0, 0, 32'hFFFFFFFC);
    step(1, 32'h123452B7, 32'h34, 0, 0, 0, 0, 0, 1, 1, 5'd5, 0, 0, 32'h12345000);
    // sw x1,-8(x2) and jal x1,+8.
    step(1, 32'hFE112C23, 32'h38, 0, 0, 0, 0, 0, 1, 1, 5'd24, 0, 32'd5, 32'hFFFFFFF8);
    step(1, 32'h008000EF, 32'h3C, 0, 0, 0, 0, 0, 1, 1, 5'd1, 0, 0, 32'd8);
    // Bubble word: invalid slot, fields still registered.
    step(1, 32'h00000000, 32'h40, 0, 0, 0, 0, 0, 1, 0, 5'd0, 0, 0, 0);
    // lw x0 is never a hazard source.
    step(1, 32'h0000A003, 32'h44, 0, 0, 0, 0, 0, 1, 1, 5'd0, 32'd5, 0, 0);
    step(1, 32'h000000B3, 32'h48, 0, 0, 0, 0, 0, 1, 1, 5'd1, 0, 0, 0);
    // Mid-run reset clears the slot and the register file.
    step(1, 32'h001283B3, 32'h4C, 0, 0, 0, 0, 0, 1, 1, 5'd7, 32'hDEADBEEF, 32'd5, 0);
    step(0, 32'h001283B3, 32'h50, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 32'h001283B3, 32'h54, 0, 0, 0, 0, 0, 1, 1, 5'd7, 0, 0, 0);

    @(negedge clk);
    i_fetch_inst = '0; i_wb_en = 1'b0; i_flush = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
